// File: rtl/aes_pkg.sv
// Shared AES-128 sequencer definitions: block width, round count, FSM encoding.
// Pure declarations, no logic.
package aes_pkg;
    localparam int AES_BLOCK_W    = 128;
    localparam int AES_NUM_ROUNDS = 10;

    typedef logic [AES_BLOCK_W-1:0] aes_block_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ROUND = 2'd1,
        DONE  = 2'd2
    } aes_state_e;
endpackage

// File: rtl/aes_round_sequencer_if.sv
// Host-side block interface: plaintext/key in over valid/ready, ciphertext out over valid/ready.
// master = host, slave = sequencer.
interface aes_round_sequencer_if;
    import aes_pkg::*;

    logic       in_valid;
    logic       in_ready;
    aes_block_t plaintext;
    aes_block_t cipher_key;
    logic       out_valid;
    logic       out_ready;
    aes_block_t ciphertext;

    modport master (
        output in_valid, plaintext, cipher_key, out_ready,
        input  in_ready, out_valid, ciphertext
    );

    modport slave (
        input  in_valid, plaintext, cipher_key, out_ready,
        output in_ready, out_valid, ciphertext
    );
endinterface

// File: rtl/aes_round_key_mux.sv
// Selects key1..key10 by round number; 0 and 11..15 select an all-zero key.
// Purely combinational, no handshake.
module aes_round_key_mux
    import aes_pkg::*;
(
    input  logic [3:0] round_cnt,
    input  aes_block_t key1,
    input  aes_block_t key2,
    input  aes_block_t key3,
    input  aes_block_t key4,
    input  aes_block_t key5,
    input  aes_block_t key6,
    input  aes_block_t key7,
    input  aes_block_t key8,
    input  aes_block_t key9,
    input  aes_block_t key10,
    output aes_block_t rnd_key
);
    always_comb begin
        rnd_key = '0;
        case (round_cnt)
            4'd1:    rnd_key = key1;
            4'd2:    rnd_key = key2;
            4'd3:    rnd_key = key3;
            4'd4:    rnd_key = key4;
            4'd5:    rnd_key = key5;
            4'd6:    rnd_key = key6;
            4'd7:    rnd_key = key7;
            4'd8:    rnd_key = key8;
            4'd9:    rnd_key = key9;
            4'd10:   rnd_key = key10;
            default: rnd_key = '0;
        endcase
    end
endmodule

// File: rtl/aes_round_sequencer.sv
// Iterative AES-128 controller: sequences an external round datapath through 10 rounds.
// Ciphertext valid 10 cycles after accept; result held in DONE until out_ready, no new accept meanwhile.
module aes_round_sequencer
    import aes_pkg::*;
#(
    parameter int NUM_ROUNDS = AES_NUM_ROUNDS,
    parameter int BLOCK_W    = AES_BLOCK_W
) (
    input  logic                 clk,
    input  logic                 reset,
    aes_round_sequencer_if.slave host,
    output logic [BLOCK_W-1:0]   aes_key,
    input  logic [BLOCK_W-1:0]   key1,
    input  logic [BLOCK_W-1:0]   key2,
    input  logic [BLOCK_W-1:0]   key3,
    input  logic [BLOCK_W-1:0]   key4,
    input  logic [BLOCK_W-1:0]   key5,
    input  logic [BLOCK_W-1:0]   key6,
    input  logic [BLOCK_W-1:0]   key7,
    input  logic [BLOCK_W-1:0]   key8,
    input  logic [BLOCK_W-1:0]   key9,
    input  logic [BLOCK_W-1:0]   key10,
    output logic [BLOCK_W-1:0]   rnd_state_out,
    output logic [BLOCK_W-1:0]   rnd_key,
    output logic                 rnd_final,
    input  logic [BLOCK_W-1:0]   rnd_state_in
);
    localparam logic [3:0] LAST_RND = 4'(NUM_ROUNDS);

    aes_state_e         st;
    logic [3:0]         round_cnt;
    logic [BLOCK_W-1:0] state_reg;
    logic [BLOCK_W-1:0] key_reg;
    logic [BLOCK_W-1:0] ct_reg;
    logic               out_vld_reg;
    logic               in_rdy_reg;
    logic [3:0]         mux_sel;

    always_ff @(posedge clk) begin
        if (reset) begin
            st          <= IDLE;
            round_cnt   <= 4'd0;
            state_reg   <= '0;
            key_reg     <= '0;
            ct_reg      <= '0;
            out_vld_reg <= 1'b0;
            in_rdy_reg  <= 1'b1;
        end else begin
            case (st)
                IDLE: begin
                    if (host.in_valid) begin
                        key_reg    <= host.cipher_key;
                        // Round-0 AddRoundKey folded into the load.
                        state_reg  <= host.plaintext ^ host.cipher_key;
                        round_cnt  <= 4'd1;
                        in_rdy_reg <= 1'b0;
                        st         <= ROUND;
                    end
                end
                ROUND: begin
                    state_reg <= rnd_state_in;
                    if (round_cnt == LAST_RND) begin
                        ct_reg      <= rnd_state_in;
                        out_vld_reg <= 1'b1;
                        round_cnt   <= 4'd0;
                        st          <= DONE;
                    end else begin
                        round_cnt <= round_cnt + 4'd1;
                    end
                end
                DONE: begin
                    if (host.out_ready) begin
                        out_vld_reg <= 1'b0;
                        in_rdy_reg  <= 1'b1;
                        st          <= IDLE;
                    end
                end
                default: st <= IDLE;
            endcase
        end
    end

    // Keys are only presented to the datapath while a round is in flight.
    assign mux_sel = (st == ROUND) ? round_cnt : 4'd0;

    aes_round_key_mux u_key_mux (
        .round_cnt (mux_sel),
        .key1      (key1),
        .key2      (key2),
        .key3      (key3),
        .key4      (key4),
        .key5      (key5),
        .key6      (key6),
        .key7      (key7),
        .key8      (key8),
        .key9      (key9),
        .key10     (key10),
        .rnd_key   (rnd_key)
    );

    assign aes_key         = key_reg;
    assign rnd_state_out   = state_reg;
    assign rnd_final       = (st == ROUND) && (round_cnt == LAST_RND);
    assign host.in_ready   = in_rdy_reg;
    assign host.out_valid  = out_vld_reg;
    assign host.ciphertext = ct_reg;
endmodule

// File: tb/tb_aes_round_sequencer.sv
// Bench for aes_round_sequencer with switchable stub / real AES key_expand and round datapath.
module tb_aes_round_sequencer;
    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic [127:0] aes_key, rnd_state_out, rnd_key, rnd_state_in;
    logic         rnd_final;
    logic [127:0] rk [11];
    logic         use_real = 1'b0;

    aes_round_sequencer_if hif ();

    aes_round_sequencer dut (
        .clk           (clk),
        .reset         (reset),
        .host          (hif),
        .aes_key       (aes_key),
        .key1          (rk[1]),
        .key2          (rk[2]),
        .key3          (rk[3]),
        .key4          (rk[4]),
        .key5          (rk[5]),
        .key6          (rk[6]),
        .key7          (rk[7]),
        .key8          (rk[8]),
        .key9          (rk[9]),
        .key10         (rk[10]),
        .rnd_state_out (rnd_state_out),
        .rnd_key       (rnd_key),
        .rnd_final     (rnd_final),
        .rnd_state_in  (rnd_state_in)
    );

    always #5 clk = ~clk;

    // ---------------- AES-128 reference functions ----------------
    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p = 8'h00;
        for (int i = 0; i < 8; i++) begin
            if (b[0]) p = p ^ a;
            a = xtime(a);
            b = b >> 1;
        end
        return p;
    endfunction

    function automatic logic [7:0] sbox(input logic [7:0] x);
        logic [7:0] p = 8'h01;
        logic [7:0] b = x;
        logic [7:0] e = 8'd254;
        for (int i = 0; i < 8; i++) begin
            if (e[i]) p = gmul(p, b);
            b = gmul(b, b);
        end
        return p ^ {p[6:0], p[7]} ^ {p[5:0], p[7:6]} ^ {p[4:0], p[7:5]} ^ {p[3:0], p[7:4]} ^ 8'h63;
    endfunction

    function automatic logic [31:0] subword(input logic [31:0] w);
        return {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
    endfunction

    function automatic logic [127:0] round_key(input logic [127:0] k, input int r);
        logic [31:0] w [44];
        logic [31:0] t;
        logic [7:0]  rc = 8'h01;
        for (int i = 0; i < 4; i++) w[i] = k[127-32*i -: 32];
        for (int i = 4; i < 44; i++) begin
            t = w[i-1];
            if (i % 4 == 0) begin
                t  = subword({t[23:0], t[31:24]}) ^ {rc, 24'h0};
                rc = xtime(rc);
            end
            w[i] = w[i-4] ^ t;
        end
        return {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
    endfunction

    function automatic logic [127:0] aes_round(input logic [127:0] s, input logic [127:0] k, input logic fin);
        logic [7:0]   sb [16];
        logic [7:0]   sh [16];
        logic [7:0]   m  [16];
        logic [127:0] o;
        for (int i = 0; i < 16; i++) sb[i] = sbox(s[127-8*i -: 8]);
        for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++) sh[r+4*c] = sb[r+4*((c+r)%4)];
        for (int c = 0; c < 4; c++) begin
            if (fin) begin
                for (int r = 0; r < 4; r++) m[r+4*c] = sh[r+4*c];
            end else begin
                m[4*c]   = gmul(8'h02, sh[4*c]) ^ gmul(8'h03, sh[4*c+1]) ^ sh[4*c+2] ^ sh[4*c+3];
                m[4*c+1] = sh[4*c] ^ gmul(8'h02, sh[4*c+1]) ^ gmul(8'h03, sh[4*c+2]) ^ sh[4*c+3];
                m[4*c+2] = sh[4*c] ^ sh[4*c+1] ^ gmul(8'h02, sh[4*c+2]) ^ gmul(8'h03, sh[4*c+3]);
                m[4*c+3] = gmul(8'h03, sh[4*c]) ^ sh[4*c+1] ^ sh[4*c+2] ^ gmul(8'h02, sh[4*c+3]);
            end
        end
        for (int i = 0; i < 16; i++) o[127-8*i -: 8] = m[i];
        return o ^ k;
    endfunction

    function automatic logic [127:0] exp_ct(input logic [127:0] pt, input logic [127:0] ck, input logic real_mode);
        logic [127:0] s;
        if (!real_mode) return pt ^ ck ^ {16{8'h0b}};
        s = pt ^ ck;
        for (int r = 1; r <= 10; r++) s = aes_round(s, round_key(ck, r), r == 10);
        return s;
    endfunction

    // Stub / real key_expand and round datapath.
    always_comb begin
        rk[0] = '0;
        for (int i = 1; i <= 10; i++) rk[i] = use_real ? round_key(aes_key, i) : {16{8'(i)}};
    end

    always_comb begin
        rnd_state_in = use_real ? aes_round(rnd_state_out, rnd_key, rnd_final) : (rnd_state_out ^ rnd_key);
    end

    // ---------------- bench model / scoreboard ----------------
    int           checks = 0;
    int           errors = 0;
    int           cyc = 0;
    logic         idle_exp = 1'b1;
    logic         done_exp = 1'b0;
    int           rnd = 0;
    logic [127:0] sb_q [$];
    logic [127:0] last_ct = '0;
    int           acc_cnt = 0, hs_cnt = 0;
    int           acc_edge = 0, hs_edge = 0, ov_edge = 0;
    logic         ov_seen = 1'b0;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, expv);
        end
    endtask

    // One cycle: sample/compare at negedge, advance model, return 1ns after the posedge.
    task automatic step();
        @(negedge clk);
        if (!reset) begin
            chk("in_ready", {127'b0, hif.in_ready}, {127'b0, idle_exp});
            chk("out_valid", {127'b0, hif.out_valid}, {127'b0, done_exp});
            if (rnd >= 1) chk("rnd_final", {127'b0, rnd_final}, {127'b0, rnd == 10});
            if (done_exp) begin
                chk("ciphertext", hif.ciphertext, sb_q[0]);
                if (!ov_seen) begin
                    ov_seen = 1'b1;
                    ov_edge = cyc;
                end
                if (hif.out_ready) begin
                    last_ct = hif.ciphertext;
                    hs_edge = cyc + 1;
                    hs_cnt++;
                end
            end
        end
        if (reset) begin
            idle_exp = 1'b1;
            done_exp = 1'b0;
            rnd      = 0;
            sb_q.delete();
        end else if (idle_exp && hif.in_valid) begin
            idle_exp = 1'b0;
            rnd      = 1;
            sb_q.push_back(exp_ct(hif.plaintext, hif.cipher_key, use_real));
            acc_edge = cyc + 1;
            acc_cnt++;
            ov_seen  = 1'b0;
        end else if (rnd >= 1 && rnd < 10) begin
            rnd++;
        end else if (rnd == 10) begin
            rnd      = 0;
            done_exp = 1'b1;
        end else if (done_exp && hif.out_ready) begin
            done_exp = 1'b0;
            idle_exp = 1'b1;
            void'(sb_q.pop_front());
        end
        @(posedge clk);
        cyc++;
        #1;
    endtask

    task automatic send(input logic [127:0] pt, input logic [127:0] ck);
        int a0 = acc_cnt;
        hif.plaintext  = pt;
        hif.cipher_key = ck;
        hif.in_valid   = 1'b1;
        for (int i = 0; i < 40 && acc_cnt == a0; i++) step();
        hif.in_valid   = 1'b0;
        hif.plaintext  = {$urandom, $urandom, $urandom, $urandom};
        hif.cipher_key = {$urandom, $urandom, $urandom, $urandom};
        chk("accept_timeout", acc_cnt, a0 + 1);
    endtask

    task automatic wait_rnd(input int target);
        for (int i = 0; i < 40 && rnd != target; i++) step();
        chk("round_wait_timeout", rnd, target);
    endtask

    task automatic drain();
        int h0 = hs_cnt;
        hif.out_ready = 1'b1;
        for (int i = 0; i < 40 && hs_cnt == h0; i++) step();
        hif.out_ready = 1'b0;
        chk("drain_timeout", hs_cnt, h0 + 1);
    endtask

    initial begin
        logic [127:0] fips_pt, fips_key, blk_a, blk_b, key_a;
        int           h0;
        fips_pt  = 128'h3243f6a8885a308d313198a2e0370734;
        fips_key = 128'h2b7e151628aed2a6abf7158809cf4f3c;
        hif.in_valid   = 1'b0;
        hif.out_ready  = 1'b0;
        hif.plaintext  = '0;
        hif.cipher_key = '0;

        step();
        step();
        reset = 1'b0;
        chk("reset_in_ready", {127'b0, hif.in_ready}, 128'd1);
        chk("reset_out_valid", {127'b0, hif.out_valid}, 128'd0);
        chk("reset_ciphertext", hif.ciphertext, 128'd0);
        chk("reset_aes_key", aes_key, 128'd0);
        chk("reset_rnd_key", rnd_key, 128'd0);
        chk("reset_rnd_final", {127'b0, rnd_final}, 128'd0);

        // Stub datapath: all-zero block and key.
        send(128'd0, 128'd0);
        for (int i = 0; i < 40 && !done_exp; i++) step();
        step();
        chk("stub_latency", ov_edge - acc_edge, 10);
        drain();
        chk("stub_ct", last_ct, {16{8'h0b}});

        // Real AES datapath: FIPS-197 vector.
        use_real = 1'b1;
        step();
        send(fips_pt, fips_key);
        chk("aes_key_reg", aes_key, fips_key);
        drain();
        chk("fips_ct", last_ct, 128'h3925841d02dc09fbdc118597196a0b32);
        chk("fips_latency", ov_edge - acc_edge, 10);

        // Backpressure: hold out_ready low for 5 cycles with result pending.
        send(128'h00112233445566778899aabbccddeeff, 128'h000102030405060708090a0b0c0d0e0f);
        for (int i = 0; i < 40 && !done_exp; i++) step();
        for (int i = 0; i < 5; i++) step();
        hif.out_ready = 1'b1;
        step();
        hif.out_ready = 1'b0;
        chk("bp_in_ready_after", {127'b0, hif.in_ready}, 128'd1);
        chk("bp_out_valid_after", {127'b0, hif.out_valid}, 128'd0);
        chk("bp_ct", last_ct, 128'h69c4e0d86a7b0430d8cdb78070b4c55a);

        // Busy ignore: second block offered during round 4.
        blk_a = 128'hdeadbeef0123456789abcdeffedcba98;
        key_a = 128'h0f1e2d3c4b5a69788796a5b4c3d2e1f0;
        send(blk_a, key_a);
        wait_rnd(4);
        hif.in_valid   = 1'b1;
        hif.plaintext  = 128'h11111111111111111111111111111111;
        hif.cipher_key = 128'h22222222222222222222222222222222;
        step();
        hif.in_valid   = 1'b0;
        h0 = hs_cnt;
        drain();
        chk("busy_ct", last_ct, exp_ct(blk_a, key_a, 1'b1));
        for (int i = 0; i < 12; i++) step();
        chk("busy_single_output", hs_cnt, h0 + 1);

        // Reset in round 6, then a fresh block.
        send(fips_pt, fips_key);
        wait_rnd(6);
        reset = 1'b1;
        step();
        reset = 1'b0;
        chk("rst_out_valid", {127'b0, hif.out_valid}, 128'd0);
        chk("rst_in_ready", {127'b0, hif.in_ready}, 128'd1);
        chk("rst_ciphertext", hif.ciphertext, 128'd0);
        step();
        send(blk_a, fips_key);
        drain();
        chk("post_rst_latency", ov_edge - acc_edge, 10);
        chk("post_rst_ct", last_ct, exp_ct(blk_a, fips_key, 1'b1));

        // Back-to-back with out_ready tied high.
        blk_b = 128'h0123456789abcdef0123456789abcdef;
        hif.out_ready = 1'b1;
        send(fips_pt, fips_key);
        hif.plaintext  = blk_b;
        hif.cipher_key = key_a;
        hif.in_valid   = 1'b1;
        h0 = acc_cnt;
        for (int i = 0; i < 40 && acc_cnt == h0; i++) step();
        hif.in_valid = 1'b0;
        chk("b2b_first_ct", last_ct, 128'h3925841d02dc09fbdc118597196a0b32);
        chk("b2b_accept_gap", acc_edge - hs_edge, 1);
        drain();
        chk("b2b_second_ct", last_ct, exp_ct(blk_b, key_a, 1'b1));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
